arm_control_unit: RTL and testbench

- Microprogrammed-style Moore FSM sequencing the ARM-subset datapath (register file, ALU, MAR/MDR, IR, flag register, 256x8 RAM).
- Fetches, decodes and executes data-processing, single LDR/STR, and B/BL instructions.
- Drives all mux selects, load enables and RAM strobes.
- Sits between the instruction register/condition tester and the datapath.

---
 rtl/arm_control_unit_if.sv | 37 +++
 rtl/arm_control_unit.sv | 131 +++++++++++++
 tb/tb_arm_control_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/arm_control_unit_if.sv
// Control bundle between the ARM-subset control unit and its datapath.
// The control unit takes the master modport; the datapath/RAM side takes the slave modport.
interface arm_control_unit_if;
  logic [31:0] IR;
  logic        MOC;
  logic        COND;
  logic        debug;
  logic        FR_ld;
  logic        RF_ld;
  logic        IR_ld;
  logic        MAR_ld;
  logic        MDR_ld;
  logic        R_W;
  logic        MOV;
  logic [1:0]  MA;
  logic [1:0]  MB;
  logic [1:0]  MC;
  logic        MD;
  logic        ME;
  logic [4:0]  OP;
  logic [1:0]  DT;
  logic [3:0]  CCU;
  logic        SIGN;
  logic [3:0]  ACU;

  modport master (
    input  IR, MOC, COND, debug,
    output FR_ld, RF_ld, IR_ld, MAR_ld, MDR_ld, R_W, MOV,
           MA, MB, MC, MD, ME, OP, DT, CCU, SIGN, ACU
  );

  modport slave (
    output IR, MOC, COND, debug,
    input  FR_ld, RF_ld, IR_ld, MAR_ld, MDR_ld, R_W, MOV,
           MA, MB, MC, MD, ME, OP, DT, CCU, SIGN, ACU
  );
endinterface

// File: rtl/arm_control_unit.sv
// Moore FSM sequencing fetch, decode and execute of ARM-subset data-processing,
// LDR/STR and B/BL instructions; every datapath control comes from state plus IR.
module arm_control_unit (
  input  logic                clk,
  input  logic                clr,
  arm_control_unit_if.master  bus
);

  typedef enum logic [3:0] {
    S0  = 4'd0,
    S1  = 4'd1,
    S2  = 4'd2,
    S3  = 4'd3,
    S4  = 4'd4,
    S5  = 4'd5,
    S6  = 4'd6,
    S7  = 4'd7,
    S8  = 4'd8,
    S9  = 4'd9,
    S10 = 4'd10,
    S12 = 4'd12,
    S13 = 4'd13
  } state_t;

  state_t state_q, state_d;

  // debug only steers simulation printing; the unused IR bits are decoded elsewhere
  logic unused_in;
  assign unused_in = ^{bus.debug, bus.IR[31:28], bus.IR[19:0]};

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= S0;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S0:  state_d = S1;
      S1:  state_d = S2;
      S2:  state_d = S3;
      S3:  state_d = bus.MOC ? S4 : S3;
      S4: begin
        if (!bus.COND)                 state_d = S1;
        else if (bus.IR[27:26] == 2'b00) state_d = S5;
        else if (bus.IR[27:26] == 2'b01) state_d = S6;
        else if (bus.IR[27:25] == 3'b101) state_d = bus.IR[24] ? S12 : S13;
        else                           state_d = S1;
      end
      S5:  state_d = S1;
      S6:  state_d = bus.IR[20] ? S9 : S7;
      S7:  state_d = S8;
      S8:  state_d = bus.MOC ? S1 : S8;
      S9:  state_d = bus.MOC ? S10 : S9;
      S10: state_d = S1;
      S12: state_d = S13;
      S13: state_d = S1;
      default: state_d = S0;
    endcase
  end

  always_comb begin
    bus.FR_ld  = 1'b0;
    bus.RF_ld  = 1'b0;
    bus.IR_ld  = 1'b0;
    bus.MAR_ld = 1'b0;
    bus.MDR_ld = 1'b0;
    bus.R_W    = 1'b0;
    bus.MOV    = 1'b0;
    bus.MA     = 2'b00;
    bus.MB     = 2'b00;
    bus.MC     = 2'b00;
    bus.MD     = 1'b0;
    bus.ME     = 1'b0;
    bus.OP     = 5'b00000;
    bus.DT     = 2'b00;
    bus.CCU    = 4'b0000;
    bus.SIGN   = 1'b0;
    bus.ACU    = 4'b0000;
    case (state_q)
      S1: begin
        bus.MA = 2'b10; bus.MB = 2'b11; bus.MD = 1'b1; bus.OP = 5'b10000;
        bus.MAR_ld = 1'b1;
      end
      S2: begin
        bus.MA = 2'b10; bus.MC = 2'b01; bus.MD = 1'b1; bus.OP = 5'b10001;
        bus.RF_ld = 1'b1;
      end
      S3: begin
        bus.MOV = 1'b1; bus.R_W = 1'b1; bus.DT = 2'b10; bus.IR_ld = 1'b1;
      end
      S5: begin
        // compare/test opcodes only update flags, never a destination register
        bus.MB = 2'b01;
        bus.RF_ld = (bus.IR[24:23] != 2'b10);
        bus.FR_ld = bus.IR[20];
      end
      S6: begin
        bus.MB = 2'b01; bus.MD = 1'b1;
        bus.OP = bus.IR[23] ? 5'b00100 : 5'b00010;
        bus.MAR_ld = 1'b1;
      end
      S7: begin
        bus.MA = 2'b01; bus.MD = 1'b1; bus.OP = 5'b10000;
        bus.ME = 1'b1; bus.MDR_ld = 1'b1;
      end
      S8: begin
        bus.MOV = 1'b1; bus.R_W = 1'b0;
        bus.DT = bus.IR[22] ? 2'b00 : 2'b10;
      end
      S9: begin
        bus.MOV = 1'b1; bus.R_W = 1'b1;
        bus.DT = bus.IR[22] ? 2'b00 : 2'b10;
        bus.MDR_ld = 1'b1;
      end
      S10: begin
        bus.MB = 2'b10; bus.MD = 1'b1; bus.OP = 5'b01101; bus.RF_ld = 1'b1;
      end
      S12: begin
        bus.MA = 2'b10; bus.MD = 1'b1; bus.OP = 5'b10000;
        bus.MC = 2'b11; bus.CCU = 4'b1110; bus.RF_ld = 1'b1;
      end
      S13: begin
        bus.MA = 2'b10; bus.MB = 2'b01; bus.MD = 1'b1; bus.OP = 5'b00100;
        bus.MC = 2'b01; bus.RF_ld = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_arm_control_unit.sv
// Directed bench for arm_control_unit: walks fetch, reset abort, data processing,
// load/store and branch-with-link sequences against hand-derived output vectors.
module tb_arm_control_unit;

  logic clk;
  logic clr;
  int   n_checks;
  int   n_fail;

  arm_control_unit_if bus ();

  arm_control_unit dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed controls packed as {FR,RF,IR,MAR,MDR,R_W,MOV,MA,MB,MC,MD,ME,OP,DT,CCU,SIGN,ACU}
  logic [30:0] obs;
  assign obs = {bus.FR_ld, bus.RF_ld, bus.IR_ld, bus.MAR_ld, bus.MDR_ld, bus.R_W, bus.MOV,
                bus.MA, bus.MB, bus.MC, bus.MD, bus.ME, bus.OP, bus.DT, bus.CCU,
                bus.SIGN, bus.ACU};

  function automatic logic [30:0] ev(
    input logic fr, input logic rf, input logic irl, input logic mar, input logic mdr,
    input logic rw, input logic mov, input logic [1:0] ma, input logic [1:0] mb,
    input logic [1:0] mc, input logic md, input logic me, input logic [4:0] op,
    input logic [1:0] dt, input logic [3:0] ccu);
    return {fr, rf, irl, mar, mdr, rw, mov, ma, mb, mc, md, me, op, dt, ccu, 1'b0, 4'b0000};
  endfunction

  task automatic check(input string tag, input logic [30:0] got, input logic [30:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  logic [30:0] e_zero, e_s1, e_s2, e_s3;

  task automatic step();
    @(negedge clk);
  endtask

  // From a negedge in S1: check S1..S3, present the instruction and MOC, land in S4.
  task automatic fetch(input string tag, input logic [31:0] ir, input logic cond);
    check({tag, "_s1"}, obs, e_s1);
    step();
    check({tag, "_s2"}, obs, e_s2);
    step();
    check({tag, "_s3"}, obs, e_s3);
    bus.IR = ir; bus.COND = cond; bus.MOC = 1'b1;
    step();
    bus.MOC = 1'b0;
    check({tag, "_s4"}, obs, e_zero);
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    e_zero = '0;
    e_s1 = ev(0,0,0,1,0,0,0,2'b10,2'b11,2'b00,1,0,5'b10000,2'b00,4'h0);
    e_s2 = ev(0,1,0,0,0,0,0,2'b10,2'b00,2'b01,1,0,5'b10001,2'b00,4'h0);
    e_s3 = ev(0,0,1,0,0,1,1,2'b00,2'b00,2'b00,0,0,5'b00000,2'b10,4'h0);
    clr = 1'b0; bus.IR = 32'h0; bus.MOC = 1'b0; bus.COND = 1'b0; bus.debug = 1'b0;

    #1 check("reset_hold", obs, e_zero);
    @(negedge clk);
    clr = 1'b1;
    step();
    check("rel_s1", obs, e_s1);
    bus.MOC = 1'b1;                       // stray MOC outside a wait state
    step();
    bus.MOC = 1'b0;
    check("moc_ign_s2", obs, e_s2);
    step();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("fetch_wait%0d", i), obs, e_s3);
      step();
    end
    #2 clr = 1'b0;
    #1 check("abort_s3", obs, e_zero);
    step();
    clr = 1'b1;
    check("abort_hold", obs, e_zero);
    step();

    fetch("add", 32'hE0821003, 1'b1);
    check("add_s5", obs, ev(0,1,0,0,0,0,0,2'b00,2'b01,2'b00,0,0,5'b00000,2'b00,4'h0));
    step();

    fetch("cmp", 32'hE1520003, 1'b1);
    check("cmp_s5", obs, ev(1,0,0,0,0,0,0,2'b00,2'b01,2'b00,0,0,5'b00000,2'b00,4'h0));
    step();

    fetch("ldr", 32'hE5912004, 1'b1);
    check("ldr_s6", obs, ev(0,0,0,1,0,0,0,2'b00,2'b01,2'b00,1,0,5'b00100,2'b00,4'h0));
    step();
    check("ldr_s9", obs, ev(0,0,0,0,1,1,1,2'b00,2'b00,2'b00,0,0,5'b00000,2'b10,4'h0));
    step();
    check("ldr_s9_hold", obs, ev(0,0,0,0,1,1,1,2'b00,2'b00,2'b00,0,0,5'b00000,2'b10,4'h0));
    bus.MOC = 1'b1;
    step();
    bus.MOC = 1'b0;
    check("ldr_s10", obs, ev(0,1,0,0,0,0,0,2'b00,2'b10,2'b00,1,0,5'b01101,2'b00,4'h0));
    step();

    fetch("strb", 32'hE5412004, 1'b1);
    check("strb_s6", obs, ev(0,0,0,1,0,0,0,2'b00,2'b01,2'b00,1,0,5'b00010,2'b00,4'h0));
    step();
    check("strb_s7", obs, ev(0,0,0,0,1,0,0,2'b01,2'b00,2'b00,1,1,5'b10000,2'b00,4'h0));
    step();
    check("strb_s8", obs, ev(0,0,0,0,0,0,1,2'b00,2'b00,2'b00,0,0,5'b00000,2'b00,4'h0));
    bus.MOC = 1'b1;
    step();
    bus.MOC = 1'b0;

    fetch("bl", 32'hEB000002, 1'b1);
    check("bl_s12", obs, ev(0,1,0,0,0,0,0,2'b10,2'b00,2'b11,1,0,5'b10000,2'b00,4'hE));
    step();
    check("bl_s13", obs, ev(0,1,0,0,0,0,0,2'b10,2'b01,2'b01,1,0,5'b00100,2'b00,4'h0));
    step();

    fetch("bl_nc", 32'hEB000002, 1'b0);
    check("bl_nc_s1", obs, e_s1);
    step();
    step();
    step();
    bus.IR = 32'hEE000000; bus.COND = 1'b1; bus.MOC = 1'b1;
    step();
    bus.MOC = 1'b0;
    check("nop_s4", obs, e_zero);
    step();
    check("nop_s1", obs, e_s1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
